dcache_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_sram.sv | 59 +++++
 rtl/dcache_ctrl.sv | 157 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, FSM state encodings and geometry helpers
// for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int BLK_W      = 256;
    localparam int WORD_OFF_W = 3;
    localparam int BYTE_OFF_W = 2;
    localparam int BLK_OFF_W  = WORD_OFF_W + BYTE_OFF_W;

    // Controller states, kept as plain constants for legacy compatibility
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WB   = 2'd1;
    localparam state_t RF   = 2'd2;

    // Tag width left over once index and block offset are taken from the address
    function automatic int tag_w(input int lines);
        return ADDR_W - $clog2(lines) - BLK_OFF_W;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: per-line valid/dirty/tag/data storage. Synchronous write,
// combinational read, single index shared by read and write.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = tag_w(LINES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLK_W-1:0]      rd_data,
    input  logic                  fill_en,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [BLK_W-1:0]      fill_data,
    input  logic                  word_en,
    input  logic [WORD_OFF_W-1:0] word_sel,
    input  logic [31:0]           word_data
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [BLK_W-1:0] data_q [LINES];

    // Status bits: reset invalidates everything, a refill installs a clean line,
    // a store hit marks the line dirty
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays are never reset; valid guards their contents
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (word_en) begin
            data_q[idx][32*int'(word_sel) +: 32] <= word_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally in the requesting cycle; misses stall through
// an optional write-back (WB) and a refill (RF).
// Optional: define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = 32,
    parameter int MEM_AW = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [BLK_W-1:0]  mem_wdata_o,
    input  logic [BLK_W-1:0]  mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = tag_w(LINES);

    state_t                  state;
    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        idx;
    logic [WORD_OFF_W-1:0]   word_sel;
    logic                    rd_valid, rd_dirty;
    logic [TAG_W-1:0]        rd_tag;
    logic [BLK_W-1:0]        rd_data;
    logic                    hit, fill_en, word_en;
    logic [ADDR_W-1:0]       victim_addr, fill_addr;
    logic                    unused_byte_off;

    assign req_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign idx             = cpu_addr_i[IDX_W+BLK_OFF_W-1 : BLK_OFF_W];
    assign word_sel        = cpu_addr_i[BLK_OFF_W-1 : BYTE_OFF_W];
    assign unused_byte_off = ^cpu_addr_i[BYTE_OFF_W-1:0];

    assign victim_addr = {rd_tag,  idx, {BLK_OFF_W{1'b0}}};
    assign fill_addr   = {req_tag, idx, {BLK_OFF_W{1'b0}}};

    assign hit     = cpu_req_i & rd_valid & (rd_tag == req_tag);
    assign fill_en = ~rst_i & (state == RF) & mem_ack_i;
    assign word_en = ~rst_i & (state == IDLE) & hit & cpu_we_i;

    dcache_sram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .fill_en   (fill_en),
        .fill_tag  (req_tag),
        .fill_data (mem_rdata_i),
        .word_en   (word_en),
        .word_sel  (word_sel),
        .word_data (cpu_wdata_i)
    );

    // The frozen pipeline holds the address, so the array still presents the victim in WB
    assign mem_wdata_o = rd_data;

    // CPU side: hit data is combinational; a miss or any non-IDLE state stalls
    always_comb begin
        cpu_rdata_o = '0;
        cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit);
        if (state == IDLE && hit) begin
            cpu_rdata_o = rd_data[32*int'(word_sel) +: 32];
        end
    end

    // Miss FSM; memory request outputs are registered alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i && !hit) begin
                        mem_req_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state      <= WB;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= MEM_AW'(victim_addr);
                        end else begin
                            state      <= RF;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= MEM_AW'(fill_addr);
                        end
                    end
                end
                WB: begin
                    if (mem_ack_i) begin
                        state      <= RF;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= MEM_AW'(fill_addr);
                    end
                end
                RF: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        mem_addr_o <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_req_o  <= 1'b0;
                    mem_we_o   <= 1'b0;
                    mem_addr_o <= '0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic just_filled;

    // Saturating counters; the hit that completes a missed access is not a real hit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
            just_filled <= 1'b0;
        end else begin
            just_filled <= fill_en;
            if (state == IDLE && hit && !just_filled && hit_cnt_o != '1) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (state == IDLE && cpu_req_i && !hit && miss_cnt_o != '1) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl. Stimulus pushes expected
// memory requests and CPU completions; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o, mem_rdata_i;
    logic         spur_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] val;
        bit          chk_val;
        int unsigned wsel;
        logic [31:0] wword;
        int unsigned stalls;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    dcache_ctrl #(.LINES(32), .MEM_AW(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt),
`endif
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Word at byte address X of main memory reads as 0xA000_0000 | X
    function automatic logic [255:0] mem_block(input logic [31:0] a);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) begin
            b[32*w +: 32] = 32'hA000_0000 | ({a[31:5], 5'b0} + 32'(4*w));
        end
        return b;
    endfunction

    function automatic void exp_mem(input bit we, input logic [31:0] addr,
                                    input int unsigned wsel, input logic [31:0] wword);
        exp_t e;
        e = '{is_mem: 1'b1, we: we, val: addr, chk_val: 1'b1, wsel: wsel, wword: wword, stalls: 0};
        sbq.push_back(e);
    endfunction

    function automatic void exp_cpu(input bit chk_val, input logic [31:0] rdata, input int unsigned stalls);
        exp_t e;
        e = '{is_mem: 1'b0, we: 1'b0, val: rdata, chk_val: chk_val, wsel: 0, wword: '0, stalls: stalls};
        sbq.push_back(e);
    endfunction

    // Memory model: ack pulses in the LAT-th cycle of each request
    initial begin
        int unsigned lat_cnt = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack_i   = spur_ack;
            mem_rdata_i = '0;
            if (mem_req_o && !rst_i) begin
                if (lat_cnt == LAT-1) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_block(mem_addr_o);
                    lat_cnt     = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: new memory requests and CPU completions pop the scoreboard
    initial begin
        bit          prev_req = 1'b0;
        bit          prev_ack = 1'b0;
        int unsigned stl = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                stl = 0; prev_req = 1'b0; prev_ack = 1'b0;
            end else begin
                if (mem_req_o && (!prev_req || prev_ack)) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_mem_req", mem_addr_o, 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk("mem_kind", 32'(1), 32'(e.is_mem));
                        chk("mem_we", 32'(mem_we_o), 32'(e.we));
                        chk("mem_addr", mem_addr_o, e.val);
                        if (e.we) chk("mem_wdata_word", mem_wdata_o[32*e.wsel +: 32], e.wword);
                    end
                end
                if (cpu_req_i) begin
                    if (cpu_stall_o) begin
                        stl++;
                    end else begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_cpu_done", cpu_addr_i, 32'hFFFF_FFFF);
                        end else begin
                            e = sbq.pop_front();
                            chk("cpu_kind", 32'(0), 32'(e.is_mem));
                            if (e.chk_val) chk("cpu_rdata", cpu_rdata_o, e.val);
                            chk("stall_cycles", stl, e.stalls);
                        end
                        stl = 0;
                    end
                end else begin
                    stl = 0;
                end
                prev_req = mem_req_o;
                prev_ack = mem_ack_i;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the access completes
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned n = 0;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
        forever begin
            @(negedge clk);
            if (!cpu_stall_o) break;
            n++;
            if (n > 50) begin
                chk("access_timeout", addr, 32'hFFFF_FFFF);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    initial begin
        int unsigned n;
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = '0; cpu_wdata_i = '0; spur_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall_o), 32'(0));
        chk("rst_mem_req", 32'(mem_req_o), 32'(0));
        chk("rst_mem_we", 32'(mem_we_o), 32'(0));
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Cold miss, then hits in the same line
        exp_mem(1'b0, 32'h40, 0, '0);
        exp_cpu(1'b1, 32'hA000_0040, LAT + 1);
        access(1'b0, 32'h40, '0);
        exp_cpu(1'b1, 32'hA000_005C, 0);
        access(1'b0, 32'h5C, '0);
        exp_cpu(1'b0, '0, 0);
        access(1'b1, 32'h44, 32'hDEAD_BEEF);
        exp_cpu(1'b1, 32'hDEAD_BEEF, 0);
        access(1'b0, 32'h44, '0);

        // Conflict miss on a dirty line: write-back then refill
        exp_mem(1'b1, 32'h40, 1, 32'hDEAD_BEEF);
        exp_mem(1'b0, 32'h440, 0, '0);
        exp_cpu(1'b1, 32'hA000_0444, 2*LAT + 1);
        access(1'b0, 32'h444, '0);

        // Different lines back to back; store merges into a freshly filled line
        exp_mem(1'b0, 32'h60, 0, '0);
        exp_cpu(1'b1, 32'hA000_0060, LAT + 1);
        access(1'b0, 32'h60, '0);
        exp_cpu(1'b0, '0, 0);
        access(1'b1, 32'h64, 32'h1234_5678);
        exp_cpu(1'b1, 32'hA000_0440, 0);
        access(1'b0, 32'h440, '0);
        exp_cpu(1'b1, 32'h1234_5678, 0);
        access(1'b0, 32'h64, '0);

        // Reset while a refill is outstanding
        exp_mem(1'b0, 32'h840, 0, '0);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h840;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_o && n < 20);
        chk("rf_req_seen", 32'(mem_req_o), 32'(1));
        @(posedge clk); #1;
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req_o), 32'(0));
        chk("abort_stall", 32'(cpu_stall_o), 32'(0));
        chk("abort_mem_addr", mem_addr_o, 32'h0);
        @(posedge clk); #1;
        exp_mem(1'b0, 32'h40, 0, '0);
        exp_cpu(1'b1, 32'hA000_0040, LAT + 1);
        access(1'b0, 32'h40, '0);

        // Spurious ack while idle with no requests
        spur_ack = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_stall", 32'(cpu_stall_o), 32'(0));
            chk("idle_mem_req", 32'(mem_req_o), 32'(0));
            chk("idle_rdata", cpu_rdata_o, 32'h0);
            @(posedge clk); #1;
            spur_ack = 1'b0;
        end
        exp_cpu(1'b1, 32'hA000_0040, 0);
        access(1'b0, 32'h40, '0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
